// File: rtl/decode.sv
// Decode stage: IF/ID pipeline register, 32x32 register file with write-through
// bypass, immediate extension and early branch/jump resolution feeding fetch.
module decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcF,
  input  logic [31:0] instrF,
  input  logic        regwriteW,
  input  logic [4:0]  write_regW,
  input  logic [31:0] resultW,
  input  logic        forwardAD,
  input  logic        forwardBD,
  input  logic [31:0] aluoutM,
  output logic [31:0] pcD,
  output logic [31:0] instrD,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [31:0] immD,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [4:0]  rdD,
  output logic        pc_srcD,
  output logic [31:0] npc
);

  typedef enum logic [5:0] {
    OP_J    = 6'h02,
    OP_JAL  = 6'h03,
    OP_BEQ  = 6'h04,
    OP_BNE  = 6'h05,
    OP_ANDI = 6'h0C,
    OP_ORI  = 6'h0D,
    OP_XORI = 6'h0E,
    OP_LUI  = 6'h0F
  } opcode_e;

  logic [31:0] r_pcD;
  logic [31:0] r_instrD;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op;
  logic [31:0] w_simm;
  logic [31:0] w_pc4D;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_pc_src;

  // IF/ID register: stall outranks flush and redirect squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcD    <= RESET_PC;
      r_instrD <= NOP;
    end else if (stallD) begin
      r_pcD    <= r_pcD;
      r_instrD <= r_instrD;
    end else if (flushD || w_pc_src) begin
      r_pcD    <= RESET_PC;
      r_instrD <= NOP;
    end else begin
      r_pcD    <= pcF;
      r_instrD <= instrF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (regwriteW && (write_regW != 5'd0)) begin
      r_rf[write_regW] <= resultW;
    end
  end

  assign pcD    = r_pcD;
  assign instrD = r_instrD;
  assign rsD    = r_instrD[25:21];
  assign rtD    = r_instrD[20:16];
  assign rdD    = r_instrD[15:11];
  assign w_op   = r_instrD[31:26];

  // Same-cycle writeback is bypassed so the file behaves as write-before-read.
  always_comb begin
    rd1D = '0;
    rd2D = '0;
    if (rsD != 5'd0) begin
      rd1D = (regwriteW && (write_regW == rsD)) ? resultW : r_rf[rsD];
    end
    if (rtD != 5'd0) begin
      rd2D = (regwriteW && (write_regW == rtD)) ? resultW : r_rf[rtD];
    end
  end

  assign w_simm = {{16{r_instrD[15]}}, r_instrD[15:0]};

  always_comb begin
    immD = w_simm;
    case (w_op)
      OP_ANDI, OP_ORI, OP_XORI: immD = {16'h0000, r_instrD[15:0]};
      OP_LUI:                   immD = {r_instrD[15:0], 16'h0000};
      default:                  immD = w_simm;
    endcase
  end

  assign w_pc4D = r_pcD + 32'd4;
  assign w_a    = forwardAD ? aluoutM : rd1D;
  assign w_b    = forwardBD ? aluoutM : rd2D;

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc4D + {w_simm[29:0], 2'b00};
    case (w_op)
      OP_BEQ: w_taken = (w_a == w_b);
      OP_BNE: w_taken = (w_a != w_b);
      OP_J, OP_JAL: begin
        w_taken  = 1'b1;
        w_target = {w_pc4D[31:28], r_instrD[25:0], 2'b00};
      end
      default: w_taken = 1'b0;
    endcase
  end

  assign w_pc_src = w_taken && !stallD;
  assign pc_srcD  = w_pc_src;
  assign npc      = w_pc_src ? w_target : (pcF + 32'd4);

endmodule
